vpu_src_port: RTL
=================

VPU_SRC_PORT -- requirements
Module: VPU_SRC_PORT

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  OPERAND_WIDTH  8   bits per lane operand
  VLANE_CNT      32  vector lanes per SRAM row
  SRAM_R_PORT_CNT 3  SRAM read ports / max source operands
  SRAM_ADDR_W    10  SRAM row address width
  SRAM_RD_LAT    1   SRAM read latency in cycles, legal 1..4
REQ-002 Ports, one per line (name, direction, width, meaning):
  clk           in   1   single clock; all logic rising-edge
  rst           in   1   asynchronous, active-high reset
  start_i       in   1   fetch request from VPU_CONTROLLER, one-cycle pulse
  src_cnt_i     in   2   number of source operands for this fetch
  src_addr_i    in   SRAM_ADDR_W x SRAM_R_PORT_CNT   row address per source
  busy_o        out  1   high whenever state is not IDLE
  sram_re_o     out  SRAM_R_PORT_CNT   per-port SRAM read enable
  sram_raddr_o  out  SRAM_ADDR_W x SRAM_R_PORT_CNT  per-port SRAM read address
  sram_rdata_i  in   OPERAND_WIDTH*VLANE_CNT x SRAM_R_PORT_CNT  SRAM read data
  rdata_o       out  OPERAND_WIDTH*VLANE_CNT x SRAM_R_PORT_CNT  operands to execution unit
  rvalid_o      out  1   rdata_o valid
  rready_i      in   1   execution unit accepts rdata_o
  done_o        out  1   one-cycle pulse, fetch completed and consumed
REQ-003 Reset: one clock only; asynchronous, active-high; the clock port is named clk and the reset port is named rst.

Function
REQ-004 FSM states: IDLE, REQ, WAIT, VALID; reset state IDLE.
REQ-005 IDLE: start_i=1 -> latch src_cnt_i (eff_cnt) and all src_addr_i, go to REQ; start_i=0 -> stay.
REQ-006 eff_cnt = min(src_cnt_i, SRAM_R_PORT_CNT); port p is enabled iff p < eff_cnt.
REQ-007 REQ lasts exactly 1 cycle: sram_re_o[p]=1 for enabled ports only, sram_raddr_o[p]=latched address; next state WAIT.
REQ-008 WAIT lasts exactly SRAM_RD_LAT cycles (down-counter); in the final WAIT cycle, sram_rdata_i[p] is captured into the holding register for enabled ports, disabled ports capture all-zero; next state VALID.
REQ-009 eff_cnt=0: REQ issues no read enables; WAIT still runs; rdata_o all zero; handshake proceeds normally.
REQ-010 VALID: rvalid_o=1, rdata_o held stable until handshake; rready_i=1 in VALID -> next state IDLE, done_o=1 for exactly the following cycle, rvalid_o=0 in that cycle.
REQ-011 rready_i outside VALID is ignored; start_i outside IDLE is ignored (no queuing).
REQ-012 start_i in the cycle done_o is high (state IDLE) is accepted.
REQ-013 Latency (SRAM_RD_LAT=L): start_i sampled at edge of cycle T -> REQ in T+1, WAIT T+2..T+1+L, rvalid_o first high in T+2+L.
REQ-014 sram_raddr_o holds the last latched value outside REQ; sram_re_o=0 in every state except REQ.
REQ-015 busy_o=1 in REQ, WAIT, VALID; busy_o=0 in IDLE.

Reset
REQ-016 On rst=1 (any state, any cycle): state IDLE; busy_o, sram_re_o, rvalid_o, done_o = 0; sram_raddr_o, rdata_o, holding registers, WAIT counter = 0.
REQ-017 Reset mid-fetch discards in-flight SRAM data; no done_o is produced for the aborted fetch; first start_i after rst deasserts is accepted normally.

Verification
REQ-018 L=1, src_cnt=3, addr={5,9,17}, rready_i tied 1: start at T -> sram_re_o=3'b111 with addrs 5/9/17 in T+1; rvalid_o in T+3 with SRAM rows 5/9/17; done_o in T+4.
REQ-019 src_cnt=1, addr0=0x3FF, L=1: only sram_re_o[0] pulses; rdata_o[1], rdata_o[2] = 0.
REQ-020 Backpressure: rready_i low 5 cycles after rvalid_o -> rvalid_o and rdata_o unchanged for 5 cycles; done_o exactly one cycle after rready_i rises.
REQ-021 start_i pulsed during WAIT and VALID -> ignored, no extra sram_re_o; start_i in the done_o cycle -> new REQ next cycle.
REQ-022 src_cnt=0 and L=3 -> no read enables; rvalid_o in T+5 with all-zero rdata_o; done_o after handshake.
REQ-023 rst asserted during WAIT -> all outputs 0 same cycle (async), no rvalid_o/done_o; subsequent fetch completes with REQ-018 timing.

Source files
------------

// File: rtl/vpu_src_port.sv
// Source-operand fetch port for the VPU: issues up to SRAM_R_PORT_CNT row reads,
// waits out the SRAM latency, then holds the operands until the execution unit accepts them.
//   state   | meaning
//   S_IDLE  | waiting for start_i
//   S_REQ   | one cycle of read enables on the active ports
//   S_WAIT  | SRAM_RD_LAT cycles; the last one captures read data
//   S_VALID | operands presented, waiting for rready_i
module vpu_src_port #(
  parameter int OPERAND_WIDTH   = 8,
  parameter int VLANE_CNT       = 32,
  parameter int SRAM_R_PORT_CNT = 3,
  parameter int SRAM_ADDR_W     = 10,
  parameter int SRAM_RD_LAT     = 1
) (
  input  logic                                                     clk,
  input  logic                                                     rst,
  input  logic                                                     start_i,
  input  logic [1:0]                                               src_cnt_i,
  input  logic [SRAM_R_PORT_CNT-1:0][SRAM_ADDR_W-1:0]              src_addr_i,
  output logic                                                     busy_o,
  output logic [SRAM_R_PORT_CNT-1:0]                               sram_re_o,
  output logic [SRAM_R_PORT_CNT-1:0][SRAM_ADDR_W-1:0]              sram_raddr_o,
  input  logic [SRAM_R_PORT_CNT-1:0][OPERAND_WIDTH*VLANE_CNT-1:0]  sram_rdata_i,
  output logic [SRAM_R_PORT_CNT-1:0][OPERAND_WIDTH*VLANE_CNT-1:0]  rdata_o,
  output logic                                                     rvalid_o,
  input  logic                                                     rready_i,
  output logic                                                     done_o
);

  localparam int DW = OPERAND_WIDTH * VLANE_CNT;
  localparam int CW = (SRAM_RD_LAT > 1) ? $clog2(SRAM_RD_LAT) : 1;
  localparam logic [CW-1:0] LAT_M1 = CW'(SRAM_RD_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_VALID} state_e;

  state_e                                   state_q;
  logic [CW-1:0]                            cnt_q;
  logic [SRAM_R_PORT_CNT-1:0]               en_q;
  logic [SRAM_R_PORT_CNT-1:0]               re_q;
  logic [SRAM_R_PORT_CNT-1:0][SRAM_ADDR_W-1:0] raddr_q;
  logic [SRAM_R_PORT_CNT-1:0][DW-1:0]       rdata_q;
  logic                                     busy_q;
  logic                                     rvalid_q;
  logic                                     done_q;

  int                                       eff_cnt;
  logic [SRAM_R_PORT_CNT-1:0]               en_d;
  logic [SRAM_R_PORT_CNT-1:0][DW-1:0]       rdata_d;

  // Requested count is clamped to the number of physical read ports.
  always_comb begin
    eff_cnt = (int'(src_cnt_i) < SRAM_R_PORT_CNT) ? int'(src_cnt_i) : SRAM_R_PORT_CNT;
    en_d    = '0;
    rdata_d = '0;
    for (int p = 0; p < SRAM_R_PORT_CNT; p++) begin
      en_d[p]    = (p < eff_cnt);
      rdata_d[p] = en_q[p] ? sram_rdata_i[p] : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      en_q     <= '0;
      re_q     <= '0;
      raddr_q  <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            en_q    <= en_d;
            re_q    <= en_d;
            raddr_q <= src_addr_i;
            busy_q  <= 1'b1;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          re_q    <= '0;
          cnt_q   <= LAT_M1;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            rdata_q  <= rdata_d;
            rvalid_q <= 1'b1;
            state_q  <= S_VALID;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_VALID: begin
          if (rready_i) begin
            rvalid_q <= 1'b0;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          re_q     <= '0;
          busy_q   <= 1'b0;
          rvalid_q <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign sram_re_o    = re_q;
  assign sram_raddr_o = raddr_q;
  assign rdata_o      = rdata_q;
  assign rvalid_o     = rvalid_q;
  assign done_o       = done_q;

endmodule
